// File: rtl/cmos_pkg.sv
// Shared types and constants for the DVP capture path (FSM states, RGB565 field widths).
package cmos_pkg;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    SKIP    = 2'd1,
    ACTIVE  = 2'd2
  } cap_state_t;

  localparam int unsigned R_W   = 5;
  localparam int unsigned G_W   = 6;
  localparam int unsigned B_W   = 5;
  localparam int unsigned PIX_W = R_W + G_W + B_W;

  // Saturating counter width able to hold max_val with headroom: $clog2(max)+1.
  function automatic int unsigned sat_cnt_w(input int unsigned max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/dvp_sync_edge.sv
// DVP input registers (s1/s2) and rise/fall strobes for vsync and href.
module dvp_sync_edge
  import cmos_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vsync_i,
  input  logic          href_i,
  input  logic [DW-1:0] d_i,
  output logic          s1_vs,
  output logic          s1_href,
  output logic [DW-1:0] s1_d,
  output logic          s2_vs,
  output logic          vs_rise,
  output logic          href_rise,
  output logic          href_fall
);

  logic          s1_vs_q, s1_vs_d;
  logic          s1_href_q, s1_href_d;
  logic [DW-1:0] s1_d_q, s1_d_d;
  logic          s2_vs_q, s2_vs_d;
  logic          s2_href_q, s2_href_d;

  always_comb begin
    s1_vs_d   = vsync_i;
    s1_href_d = href_i;
    s1_d_d    = d_i;
    s2_vs_d   = s1_vs_q;
    s2_href_d = s1_href_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vs_q   <= 1'b0;
      s1_href_q <= 1'b0;
      s1_d_q    <= '0;
      s2_vs_q   <= 1'b0;
      s2_href_q <= 1'b0;
    end else begin
      s1_vs_q   <= s1_vs_d;
      s1_href_q <= s1_href_d;
      s1_d_q    <= s1_d_d;
      s2_vs_q   <= s2_vs_d;
      s2_href_q <= s2_href_d;
    end
  end

  assign s1_vs     = s1_vs_q;
  assign s1_href   = s1_href_q;
  assign s1_d      = s1_d_q;
  assign s2_vs     = s2_vs_q;
  assign vs_rise   = s1_vs_q & ~s2_vs_q;
  assign href_rise = s1_href_q & ~s2_href_q;
  assign href_fall = ~s1_href_q & s2_href_q;

endmodule

// File: rtl/cmos_dvp_capture.sv
// DVP byte stream capture: frame skip FSM, RGB565 byte-pair packer, line/frame checkers.
// Optional CMOS_DVP_STAT_EN adds stat_width/stat_height measurement outputs.
module cmos_dvp_capture
  import cmos_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SKIP_FRAMES = 10,
  parameter int unsigned HIGH_FIRST  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmos_vsync,
  input  logic             cmos_href,
  input  logic [7:0]       cmos_d,
  output logic             out_vs,
  output logic             out_de,
  output logic [PIX_W-1:0] out_data,
  output logic             frame_valid,
  output logic             err_line,
  output logic             err_frame
`ifdef CMOS_DVP_STAT_EN
  ,
  output logic [15:0]      stat_width,
  output logic [15:0]      stat_height
`endif
);

  localparam int unsigned PW = sat_cnt_w(H_ACTIVE);
  localparam int unsigned LW = sat_cnt_w(V_ACTIVE);
  localparam int unsigned SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [PW-1:0] H_EXP     = PW'(H_ACTIVE);
  localparam logic [LW-1:0] V_EXP     = LW'(V_ACTIVE);
  localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP_FRAMES - 1);

  logic       s1_vs, s1_href, s2_vs, vs_rise, href_rise, href_fall;
  logic [7:0] s1_d;

  dvp_sync_edge #(.DW(8)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync_i   (cmos_vsync),
    .href_i    (cmos_href),
    .d_i       (cmos_d),
    .s1_vs     (s1_vs),
    .s1_href   (s1_href),
    .s1_d      (s1_d),
    .s2_vs     (s2_vs),
    .vs_rise   (vs_rise),
    .href_rise (href_rise),
    .href_fall (href_fall)
  );

  cap_state_t       state_q, state_d;
  logic [SW-1:0]    skip_cnt_q, skip_cnt_d;
  logic             byte_phase_q, byte_phase_d;
  logic [7:0]       byte_q, byte_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             pix_vld_q, pix_vld_d;
  logic [PW-1:0]    pix_cnt_q, pix_cnt_d;
  logic [LW-1:0]    line_cnt_q, line_cnt_d;
  logic             frame_armed_q, frame_armed_d;
  logic             out_de_q, out_de_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic             err_line_q, err_line_d;
  logic             err_frame_q, err_frame_d;
`ifdef CMOS_DVP_STAT_EN
  logic [15:0]      stat_width_q, stat_width_d;
  logic [15:0]      stat_height_q, stat_height_d;
`endif

  logic          active, byte_cycle, phase_cur, line_end, line_err, frame_err;
  logic [LW-1:0] line_cnt_eff;

  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    byte_d        = byte_q;
    pix_d         = pix_q;
    pix_vld_d     = 1'b0;
    pix_cnt_d     = pix_cnt_q;
    frame_armed_d = frame_armed_q;
    line_err      = 1'b0;
    frame_err     = 1'b0;
`ifdef CMOS_DVP_STAT_EN
    stat_width_d  = stat_width_q;
    stat_height_d = stat_height_q;
`endif

    active     = (state_q == ACTIVE);
    byte_cycle = s1_href & ~s1_vs;
    phase_cur  = href_rise ? 1'b0 : byte_phase_q;
    // A line counts only if its last byte cycle was outside vsync; this keeps
    // a line ending on the same cycle as vs_rise inside the closing frame.
    line_end   = href_fall & ~s2_vs;

    byte_phase_d = byte_cycle ? ~phase_cur : phase_cur;
    if (byte_cycle) begin
      if (!phase_cur) begin
        byte_d = s1_d;
      end else begin
        pix_d     = (HIGH_FIRST != 0) ? {byte_q, s1_d} : {s1_d, byte_q};
        pix_vld_d = 1'b1;
        if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + 1'b1;
      end
    end

    line_cnt_eff = line_cnt_q;
    if (line_end) begin
      line_err = byte_phase_q | (pix_cnt_q != H_EXP);
      if (line_cnt_q != '1) line_cnt_eff = line_cnt_q + 1'b1;
`ifdef CMOS_DVP_STAT_EN
      stat_width_d = 16'(pix_cnt_q);
`endif
    end
    if (href_fall) pix_cnt_d = '0;

    line_cnt_d = line_cnt_eff;
    if (vs_rise) begin
      frame_err  = active & frame_armed_q & (line_cnt_eff != V_EXP);
      line_cnt_d = '0;
      if (active) frame_armed_d = 1'b1;
`ifdef CMOS_DVP_STAT_EN
      stat_height_d = 16'(line_cnt_eff);
`endif
    end

    case (state_q)
      WAIT_VS: begin
        if (vs_rise) begin
          if (SKIP_FRAMES > 0) state_d = SKIP;
          else                 state_d = ACTIVE;
        end
      end
      SKIP: begin
        if (vs_rise) begin
          skip_cnt_d = skip_cnt_q + 1'b1;
          if (skip_cnt_q == SKIP_LAST) state_d = ACTIVE;
        end
      end
      ACTIVE:  state_d = ACTIVE;
      default: state_d = WAIT_VS;
    endcase

    out_de_d    = pix_vld_q & active;
    out_data_d  = (pix_vld_q & active) ? pix_q : out_data_q;
    err_line_d  = line_err & active;
    err_frame_d = frame_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_VS;
      skip_cnt_q    <= '0;
      byte_phase_q  <= 1'b0;
      byte_q        <= '0;
      pix_q         <= '0;
      pix_vld_q     <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      frame_armed_q <= 1'b0;
      out_de_q      <= 1'b0;
      out_data_q    <= '0;
      err_line_q    <= 1'b0;
      err_frame_q   <= 1'b0;
`ifdef CMOS_DVP_STAT_EN
      stat_width_q  <= '0;
      stat_height_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      byte_phase_q  <= byte_phase_d;
      byte_q        <= byte_d;
      pix_q         <= pix_d;
      pix_vld_q     <= pix_vld_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      frame_armed_q <= frame_armed_d;
      out_de_q      <= out_de_d;
      out_data_q    <= out_data_d;
      err_line_q    <= err_line_d;
      err_frame_q   <= err_frame_d;
`ifdef CMOS_DVP_STAT_EN
      stat_width_q  <= stat_width_d;
      stat_height_q <= stat_height_d;
`endif
    end
  end

  assign out_vs      = s2_vs & active;
  assign out_de      = out_de_q;
  assign out_data    = out_data_q;
  assign frame_valid = active;
  assign err_line    = err_line_q;
  assign err_frame   = err_frame_q;
`ifdef CMOS_DVP_STAT_EN
  assign stat_width  = stat_width_q;
  assign stat_height = stat_height_q;
`endif

endmodule

// File: doc/cmos_dvp_capture.md
Name: cmos_dvp_capture

Overview:
- Captures an 8-bit DVP camera byte stream (vsync/href/data) and packs byte pairs into RGB565 pixels with a one-cycle `out_de` strobe per pixel and a frame-level `out_vs`.
- Sits directly upstream of the Gaussian filter stage and feeds its `in_vs`/`in_de`/`in_data`.
- Drops the first SKIP_FRAMES frames after reset while the sensor settles.
- Flags malformed lines and frames.

Parameters:
- H_ACTIVE, 800: expected pixels per line (bytes per line = 2*H_ACTIVE).
- V_ACTIVE, 480: expected lines per frame.
- SKIP_FRAMES, 10: complete frames discarded after reset before output is enabled (0 = output from the first full frame).
- HIGH_FIRST, 1: 1 = first byte of a pair is out_data[15:8]; 0 = first byte is out_data[7:0].

Ports:
- clk  in  1  pixel-byte clock
- rst_n  in  1  asynchronous active-low reset
- cmos_vsync  in  1  frame sync, active high, high during vertical blanking
- cmos_href  in  1  line valid, active high
- cmos_d  in  8  camera data byte
- out_vs  out  1  frame sync to downstream, active high
- out_de  out  1  pixel strobe, one cycle per pixel
- out_data  out  16  RGB565 pixel, valid when out_de=1
- frame_valid  out  1  high while the capture FSM is in ACTIVE
- err_line  out  1  one-cycle pulse: bad line length or odd byte count
- err_frame  out  1  one-cycle pulse: bad line count at frame end

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: every output is 0. All counters and byte_phase are 0, the FSM is in WAIT_VS, and input registers are cleared.
- Input stage: cmos_vsync, cmos_href and cmos_d are registered once (s1). Edge detection compares s1 with a second register (s2).
- vs_rise = s1_vs & ~s2_vs; href_rise and href_fall are defined likewise.
- FSM:
  - WAIT_VS: on vs_rise, go to SKIP if SKIP_FRAMES>0, else go to ACTIVE.
  - SKIP: skip_cnt increments on each vs_rise; when skip_cnt == SKIP_FRAMES-1 at a vs_rise, go to ACTIVE.
  - ACTIVE: stays there until reset.
- Frames overlapping reset release are never output; the first output frame always begins at a vs_rise.
- Packing:
  - byte_phase clears on href_rise and toggles on every cycle with s1_href=1 and s1_vs=0.
  - Phase 0 stores the byte. Phase 1 forms the pixel.
  - In ACTIVE only: the pixel is registered to out_data and out_de=1 on the next cycle.
- Latency: a second byte present on cmos_d at edge N produces out_de=1 with its pixel after edge N+2.
- out_vs: s1_vs delayed one more register (2 cycles total), ANDed with "FSM in ACTIVE", so it stays aligned with out_de. It is forced 0 outside ACTIVE.
- href while s1_vs=1 is ignored; no bytes are counted or packed.
- Line check at href_fall:
  - err_line pulses if byte_phase=1 (odd byte count; the dangling byte is discarded, no pixel).
  - err_line also pulses if pix_cnt != H_ACTIVE.
  - pix_cnt then clears. Checks run in all FSM states, but pulses are only emitted in ACTIVE.
- Frame check at vs_rise:
  - err_frame pulses if line_cnt != V_ACTIVE, in ACTIVE only.
  - The pulse is suppressed at the first vs_rise after entering ACTIVE.
  - line_cnt (incremented at each href_fall) clears.
- Counter widths: pix_cnt and line_cnt saturate at all-ones (width = $clog2(max)+1); no wrap. skip_cnt is $clog2(SKIP_FRAMES+1) bits.
- Simultaneous href_fall and vs_rise: the line check is evaluated first, line_cnt includes that line, then the frame check runs.
- Reset mid-frame: outputs drop to 0 immediately (asynchronously). After release the FSM waits in WAIT_VS; skipping restarts from 0.

Optional Feature:
- Macro: CMOS_DVP_STAT_EN.
- When defined: adds outputs stat_width[15:0] and stat_height[15:0]. At every href_fall, stat_width latches the pixel count. At every vs_rise, stat_height latches the line count. Both are valid in all FSM states and reset to 0.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package cmos_pkg:
  - FSM enum typedef cap_state_t {WAIT_VS, SKIP, ACTIVE}.
  - RGB565 field width constants R_W=5, G_W=6, B_W=5.
- One natural sub-module: dvp_sync_edge, which holds the s1/s2 input registers and produces the rise/fall strobes for vsync and href.
- The FSM, packer and checkers stay in the top module.

Test Plan:
- Skip phase: SKIP_FRAMES=2, 4 clean frames of 4x2 pixels (H_ACTIVE=4, V_ACTIVE=2).
  - out_de stays 0 for frames 1-2.
  - Frames 3-4 give exactly 8 out_de pulses each.
  - frame_valid rises at the 3rd vs_rise.
- Packing: bytes 0xF8,0x1F in ACTIVE with HIGH_FIRST=1.
  - out_data=0xF81F with out_de exactly 2 cycles after 0x1F is sampled.
  - With HIGH_FIRST=0: out_data=0x1FF8.
- Odd line: line of 7 bytes with H_ACTIVE=4.
  - 3 pixels output, the 7th byte is dropped.
  - err_line pulses once, 1 cycle wide, after href falls.
- Bad frame: 3 lines with V_ACTIVE=2 in ACTIVE.
  - err_frame pulses once at the next vs_rise.
  - No err_frame at the first vs_rise after entering ACTIVE.
- Mid-frame reset: assert rst_n=0 during pixel 2 of line 1.
  - All outputs 0 immediately.
  - After release, no out_de until SKIP_FRAMES frames plus a new vs_rise have passed.
- Stats (CMOS_DVP_STAT_EN defined): frame of 4x2 pixels.
  - stat_width=4 after the first href_fall.
  - stat_height=2 after the next vs_rise.
